// File: rtl/tl_pkg.sv
// Shared constants for the intersection phase sequencer: state encodings,
// lamp codes and helpers that tell which timer a state waits on.
package tl_pkg;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StClear    = 3'd1;
    localparam logic [2:0] StNsGreen  = 3'd2;
    localparam logic [2:0] StNsYellow = 3'd3;
    localparam logic [2:0] StEwGreen  = 3'd4;
    localparam logic [2:0] StEwYellow = 3'd5;
    localparam logic [2:0] StPedWalk  = 3'd6;
    localparam logic [2:0] StEmerg    = 3'd7;

    // Lamp codes are {red, yellow, green}
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    function automatic logic is_10s_state(input logic [2:0] s);
        return (s == StClear) || (s == StNsYellow) || (s == StEwYellow) || (s == StPedWalk);
    endfunction

    function automatic logic is_20s_state(input logic [2:0] s);
        return (s == StNsGreen) || (s == StEwGreen);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection phase sequencer with pedestrian insertion, emergency
// all-red override and enable gate; drives an external 10 s / 20 s timer.
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned CYC_W  = 8,
    parameter bit          PED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             emergency,
    input  logic             ped_req,
    input  logic             done_10s,
    input  logic             done_20s,
    output logic             start_10s,
    output logic             start_20s,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             ped_walk,
    output logic             ped_pending,
    output logic [2:0]       state_o,
    output logic [CYC_W-1:0] cycle_cnt
);

    logic [2:0]       state_q, state_d;
    logic             next_dir_q, next_dir_d;
    logic             ped_pending_q, ped_pending_d;
    logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             start_10s_q, start_10s_d;
    logic             start_20s_q, start_20s_d;

    logic done_ok;
    logic ped_go;
    logic entering;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            next_dir_q    <= 1'b0;
            ped_pending_q <= 1'b0;
            cycle_cnt_q   <= '0;
            start_10s_q   <= 1'b0;
            start_20s_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
            cycle_cnt_q   <= cycle_cnt_d;
            start_10s_q   <= start_10s_d;
            start_20s_q   <= start_20s_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        // A done coinciding with our own start pulse belongs to an earlier timer run
        done_ok = !(start_10s_q || start_20s_q) &&
                  ((is_10s_state(state_q) && done_10s) || (is_20s_state(state_q) && done_20s));
        ped_go  = PED_EN && (ped_pending_q || ped_req);

        if (emergency) begin
            state_d = StEmerg;
        end else if (!enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StEmerg: state_d = StClear;
                StClear:    if (done_ok) state_d = StNsGreen;
                StNsGreen:  if (done_ok) state_d = StNsYellow;
                StNsYellow: begin
                    if (done_ok) begin
                        if (ped_go) begin
                            state_d    = StPedWalk;
                            next_dir_d = 1'b1;
                        end else begin
                            state_d = StEwGreen;
                        end
                    end
                end
                StEwGreen:  if (done_ok) state_d = StEwYellow;
                StEwYellow: begin
                    if (done_ok) begin
                        if (ped_go) begin
                            state_d    = StPedWalk;
                            next_dir_d = 1'b0;
                        end else begin
                            state_d = StNsGreen;
                        end
                    end
                end
                StPedWalk:  if (done_ok) state_d = next_dir_q ? StEwGreen : StNsGreen;
                default:    state_d = StIdle;
            endcase
        end

        entering    = (state_d != state_q);
        start_10s_d = entering && is_10s_state(state_d);
        start_20s_d = entering && is_20s_state(state_d);

        cycle_cnt_d = cycle_cnt_q;
        if ((state_q == StEwYellow) && done_ok && !emergency && enable) begin
            cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
        end

        ped_pending_d = ped_pending_q;
        if (!PED_EN) begin
            ped_pending_d = 1'b0;
        end else if (entering && ((state_d == StPedWalk) || (state_d == StIdle))) begin
            ped_pending_d = 1'b0;
        end else if (ped_req) begin
            ped_pending_d = 1'b1;
        end
    end

    always_comb begin
        ns_light = L_RED;
        ew_light = L_RED;
        ped_walk = 1'b0;
        case (state_q)
            StNsGreen:  ns_light = L_GRN;
            StNsYellow: ns_light = L_YEL;
            StEwGreen:  ew_light = L_GRN;
            StEwYellow: ew_light = L_YEL;
            StPedWalk:  ped_walk = 1'b1;
            default:    ;
        endcase
        start_10s   = start_10s_q;
        start_20s   = start_20s_q;
        ped_pending = ped_pending_q;
        state_o     = state_q;
        cycle_cnt   = cycle_cnt_q;
    end

endmodule
